// File: rtl/fab_cfg_pkg.sv
// Shared types and constants for frame_config_sequencer: opcodes, FSM states,
// default geometry/sync word and the command-word field layout.
package fab_cfg_pkg;

  localparam int WORD_W = 32;

  localparam int NUM_COLUMNS_DEF    = 8;
  localparam int FRAMES_PER_COL_DEF = 20;
  localparam int FRAME_BITS_DEF     = 32;
  localparam logic [WORD_W-1:0] SYNC_WORD_DEF = 32'hFAB0_FAB1;

  // Command word: [31:28] opcode, [15:8] column, [7:0] frame; [27:16] ignored.
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 28;
  localparam int COL_MSB = 15;
  localparam int COL_LSB = 8;
  localparam int FRM_MSB = 7;
  localparam int FRM_LSB = 0;

  typedef enum logic [3:0] {
    OP_DESYNC = 4'd0,
    OP_WRITE  = 4'd1,
    OP_CHECK  = 4'd2
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_DATA   = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4,
    ST_CHECK  = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_config_sequencer_if.sv
// Valid/ready word stream from the config port bridge into frame_config_sequencer.
interface frame_config_sequencer_if;
  import fab_cfg_pkg::*;

  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/frame_strobe_decoder.sv
// Combinational decode of the registered column/frame address into the one-hot
// FrameStrobe vector (bit col*FRAMES_PER_COL+frame); all zero when en is low.
module frame_strobe_decoder #(
  parameter int NUM_COLUMNS    = 8,
  parameter int FRAMES_PER_COL = 20,
  parameter int COL_W          = 3,
  parameter int FRM_W          = 5
) (
  input  logic                                  en,
  input  logic [COL_W-1:0]                      col,
  input  logic [FRM_W-1:0]                      frame,
  output logic [NUM_COLUMNS*FRAMES_PER_COL-1:0] strobe
);

  always_comb begin
    strobe = '0;
    for (int c = 0; c < NUM_COLUMNS; c++) begin
      for (int f = 0; f < FRAMES_PER_COL; f++) begin
        strobe[c*FRAMES_PER_COL + f] = en && (col == COL_W'(c)) && (frame == FRM_W'(f));
      end
    end
  end

endmodule

// File: rtl/frame_config_sequencer.sv
// Parses the config word stream and writes frames into the fabric via FrameData/FrameStrobe.
// Define CONFIG_CHECKSUM_EN to add the running data-word sum and the CHECK command.
//   state  | meaning
//   IDLE   | no session, waiting for SYNC_WORD
//   CMD    | expecting a command word (SYNC here re-syncs)
//   DATA   | expecting the frame payload for the latched address
//   STROBE | payload on FrameData, strobe armed
//   HOLD   | one FrameStrobe bit high, FrameData stable
//   CHECK  | expecting the checksum word
//   ERR    | error latched, dropping words until SYNC_WORD
module frame_config_sequencer
  import fab_cfg_pkg::*;
#(
  parameter int                NUM_COLUMNS    = NUM_COLUMNS_DEF,
  parameter int                FRAMES_PER_COL = FRAMES_PER_COL_DEF,
  parameter int                FRAME_BITS     = FRAME_BITS_DEF,
  parameter logic [WORD_W-1:0] SYNC_WORD      = SYNC_WORD_DEF
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  frame_config_sequencer_if.slave               bus,
  output logic [FRAME_BITS-1:0]                 FrameData,
  output logic [NUM_COLUMNS*FRAMES_PER_COL-1:0] FrameStrobe,
  output logic                                  cfg_busy,
  output logic                                  cfg_done,
  output logic                                  cfg_error
);

  localparam int COL_W = clog2_min1(NUM_COLUMNS);
  localparam int FRM_W = clog2_min1(FRAMES_PER_COL);

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] frame_data_q, frame_data_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [FRM_W-1:0]      frm_q, frm_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
`ifdef CONFIG_CHECKSUM_EN
  logic [WORD_W-1:0]     sum_q, sum_d;
`endif

  logic    accept;
  logic    is_sync;
  logic    addr_ok;
  logic    strobe_en;
  opcode_e opc;

  assign accept  = bus.s_valid && bus.s_ready;
  assign is_sync = (bus.s_data == SYNC_WORD);
  assign opc     = opcode_e'(bus.s_data[OPC_MSB:OPC_LSB]);
  assign addr_ok = (32'(bus.s_data[COL_MSB:COL_LSB]) < NUM_COLUMNS) &&
                   (32'(bus.s_data[FRM_MSB:FRM_LSB]) < FRAMES_PER_COL);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && is_sync) state_d = ST_CMD;
      end
      ST_CMD: begin
        if (accept && !is_sync) begin
          case (opc)
            OP_WRITE:  state_d = addr_ok ? ST_DATA : ST_ERR;
            OP_DESYNC: state_d = ST_IDLE;
`ifdef CONFIG_CHECKSUM_EN
            OP_CHECK:  state_d = ST_CHECK;
`endif
            default:   state_d = ST_ERR;
          endcase
        end
      end
      ST_DATA: begin
        if (accept) state_d = ST_STROBE;
      end
      ST_STROBE: state_d = ST_HOLD;
      ST_HOLD:   state_d = ST_CMD;
      ST_CHECK: begin
`ifdef CONFIG_CHECKSUM_EN
        if (accept) state_d = (bus.s_data == sum_q) ? ST_CMD : ST_ERR;
`else
        state_d = ST_ERR;
`endif
      end
      ST_ERR: begin
        if (accept && is_sync) state_d = ST_CMD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The strobe fires from HOLD so the decoder sees an address and payload that are already registered.
  always_comb begin
    bus.s_ready = 1'b1;
    cfg_busy    = 1'b1;
    strobe_en   = 1'b0;
    case (state_q)
      ST_IDLE:   cfg_busy = 1'b0;
      ST_STROBE: bus.s_ready = 1'b0;
      ST_HOLD: begin
        bus.s_ready = 1'b0;
        strobe_en   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    frame_data_d = frame_data_q;
    col_d        = col_q;
    frm_d        = frm_q;
    done_d       = 1'b0;
    error_d      = error_q;
    if (accept) begin
      if (state_q == ST_DATA) begin
        frame_data_d = FRAME_BITS'(bus.s_data);
      end
      if (state_q == ST_CMD && !is_sync && opc == OP_WRITE && addr_ok) begin
        col_d = COL_W'(bus.s_data[COL_MSB:COL_LSB]);
        frm_d = FRM_W'(bus.s_data[FRM_MSB:FRM_LSB]);
      end
      if (state_q == ST_CMD && !is_sync && opc == OP_DESYNC) begin
        done_d = 1'b1;
      end
      if ((state_q == ST_IDLE || state_q == ST_ERR) && is_sync) begin
        error_d = 1'b0;
      end
    end
    if (state_d == ST_ERR) error_d = 1'b1;
  end

`ifdef CONFIG_CHECKSUM_EN
  // A SYNC word only restarts the sum where it is parsed as SYNC, never as DATA payload.
  always_comb begin
    sum_d = sum_q;
    if (accept) begin
      if (is_sync && (state_q == ST_IDLE || state_q == ST_CMD || state_q == ST_ERR)) begin
        sum_d = '0;
      end else if (state_q == ST_DATA) begin
        sum_d = sum_q + bus.s_data;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      frame_data_q <= '0;
      col_q        <= '0;
      frm_q        <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      frame_data_q <= frame_data_d;
      col_q        <= col_d;
      frm_q        <= frm_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  frame_strobe_decoder #(
    .NUM_COLUMNS    (NUM_COLUMNS),
    .FRAMES_PER_COL (FRAMES_PER_COL),
    .COL_W          (COL_W),
    .FRM_W          (FRM_W)
  ) u_strobe_dec (
    .en     (strobe_en),
    .col    (col_q),
    .frame  (frm_q),
    .strobe (FrameStrobe)
  );

  assign FrameData = frame_data_q;
  assign cfg_done  = done_q;
  assign cfg_error = error_q;

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Bench for frame_config_sequencer: directed scenarios plus a randomized word stream
// scored against a word-level model of the command protocol.
module tb_frame_config_sequencer;
  import fab_cfg_pkg::*;

  localparam int NC   = 8;
  localparam int FPC  = 20;
  localparam int FB   = 32;
  localparam int NSTB = NC * FPC;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;
  localparam int EXP_CMD  = 0;
  localparam int EXP_DATA = 1;
  localparam int EXP_SUM  = 2;
`ifdef CONFIG_CHECKSUM_EN
  localparam bit CHECKSUM_ON = 1'b1;
`else
  localparam bit CHECKSUM_ON = 1'b0;
`endif

  logic            CLK;
  logic            RST;
  logic [FB-1:0]   FrameData;
  logic [NSTB-1:0] FrameStrobe;
  logic            cfg_busy;
  logic            cfg_done;
  logic            cfg_error;

  frame_config_sequencer_if bus();

  frame_config_sequencer dut (
    .CLK         (CLK),
    .RST         (RST),
    .bus         (bus),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .cfg_busy    (cfg_busy),
    .cfg_done    (cfg_done),
    .cfg_error   (cfg_error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Word-level reference: session/error flags, what the next word means, running sum.
  typedef struct {
    int          idx;
    logic [31:0] data;
    int          cyc;
  } exp_strobe_t;

  exp_strobe_t exp_q[$];
  bit          m_session;
  bit          m_err;
  int          m_expect;
  logic [31:0] m_sum;
  int          m_col;
  int          m_frm;
  int          m_done_cnt = 0;
  int          done_seen  = 0;

  function automatic void model_reset();
    m_session = 1'b0;
    m_err     = 1'b0;
    m_expect  = EXP_CMD;
    m_sum     = '0;
    exp_q.delete();
  endfunction

  function automatic void model_word(input logic [31:0] w, input int acc,
                                     output bit is_data, output bit is_desync);
    int op;
    int col;
    int frm;
    exp_strobe_t e;
    is_data   = 1'b0;
    is_desync = 1'b0;
    if (!m_session || m_err) begin
      if (w == SYNC) begin
        m_session = 1'b1;
        m_err     = 1'b0;
        m_sum     = '0;
        m_expect  = EXP_CMD;
      end
      return;
    end
    if (m_expect == EXP_DATA) begin
      is_data  = 1'b1;
      e.idx    = m_col * FPC + m_frm;
      e.data   = w;
      e.cyc    = acc + 1;
      exp_q.push_back(e);
      m_sum    = m_sum + w;
      m_expect = EXP_CMD;
      return;
    end
    if (m_expect == EXP_SUM) begin
      if (w != m_sum) m_err = 1'b1;
      m_expect = EXP_CMD;
      return;
    end
    if (w == SYNC) begin
      m_sum = '0;
      return;
    end
    op  = int'(w[31:28]);
    col = int'(w[15:8]);
    frm = int'(w[7:0]);
    if (op == 1 && col < NC && frm < FPC) begin
      m_col    = col;
      m_frm    = frm;
      m_expect = EXP_DATA;
    end else if (op == 0) begin
      m_session = 1'b0;
      is_desync = 1'b1;
      m_done_cnt++;
    end else if (op == 2 && CHECKSUM_ON) begin
      m_expect = EXP_SUM;
    end else begin
      m_err = 1'b1;
    end
  endfunction

  function automatic int strobe_index(input logic [NSTB-1:0] s);
    for (int i = 0; i < NSTB; i++) if (s[i]) return i;
    return -1;
  endfunction

  always @(negedge CLK) begin
    if (cfg_done) done_seen++;
    if (FrameStrobe != '0) begin
      check_eq("strobe_onehot", 64'($countones(FrameStrobe)), 64'd1);
      if (exp_q.size() == 0) begin
        check_eq("strobe_unexpected", 64'($countones(FrameStrobe)), 64'd0);
      end else begin
        exp_strobe_t e;
        e = exp_q.pop_front();
        check_eq("strobe_idx", 64'(strobe_index(FrameStrobe)), 64'(e.idx));
        check_eq("strobe_data", 64'(FrameData), 64'(e.data));
        check_eq("strobe_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  int acc_tmp;

  task automatic send_word(input logic [31:0] w, input int gap, output int acc_o);
    int budget;
    bit was_data;
    bit was_desync;
    bus.s_valid = 1'b0;
    repeat (gap) @(negedge CLK);
    bus.s_data  = w;
    bus.s_valid = 1'b1;
    budget = 20;
    while (!bus.s_ready && budget > 0) begin
      @(negedge CLK);
      budget--;
    end
    if (budget == 0) check_eq("ready_timeout", 64'(bus.s_ready), 64'd1);
    @(posedge CLK);
    @(negedge CLK);
    bus.s_valid = 1'b0;
    acc_o = cyc;
    model_word(w, acc_o, was_data, was_desync);
    check_eq("busy", 64'(cfg_busy), 64'(m_session));
    check_eq("error", 64'(cfg_error), 64'(m_err));
    check_eq("done", 64'(cfg_done), 64'(was_desync));
    check_eq("ready", 64'(bus.s_ready), 64'(!was_data));
    if (was_data) check_eq("frame_data", 64'(FrameData), 64'(w));
  endtask

  task automatic sw(input logic [31:0] w);
    send_word(w, 0, acc_tmp);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

  int          acc_a;
  int          acc_b;
  int          r;
  logic [31:0] w;

  initial begin
    RST         = 1'b0;
    bus.s_data  = '0;
    bus.s_valid = 1'b0;
    model_reset();
    #2 RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check_eq("rst_frame_data", 64'(FrameData), 64'd0);
    check_eq("rst_strobe", 64'($countones(FrameStrobe)), 64'd0);
    check_eq("rst_ready", 64'(bus.s_ready), 64'd1);
    check_eq("rst_busy", 64'(cfg_busy), 64'd0);
    check_eq("rst_done", 64'(cfg_done), 64'd0);
    check_eq("rst_error", 64'(cfg_error), 64'd0);

    // Words before SYNC are dropped.
    repeat (3) sw(32'h1234_5678);
    check_eq("t2_busy", 64'(cfg_busy), 64'd0);

    // Single frame write to column 3, frame 5.
    sw(SYNC);
    sw(32'h1000_0305);
    send_word(32'hDEAD_BEEF, 0, acc_a);
    check_eq("t1_data_next_cycle", 64'(FrameData), 64'hDEAD_BEEF);
    check_eq("t1_no_early_strobe", 64'($countones(FrameStrobe)), 64'd0);
    @(negedge CLK); #1;
    check_eq("t1_strobe_idx", 64'(strobe_index(FrameStrobe)), 64'd65);
    check_eq("t1_strobe_count", 64'($countones(FrameStrobe)), 64'd1);
    @(negedge CLK); #1;
    check_eq("t1_strobe_off", 64'($countones(FrameStrobe)), 64'd0);
    check_eq("t1_data_held", 64'(FrameData), 64'hDEAD_BEEF);

    // Out-of-range addresses latch the error until the next SYNC.
    sw(SYNC);
    sw(32'h1000_0800);
    check_eq("t3_err_set", 64'(cfg_error), 64'd1);
    sw(32'hDEAD_BEEF);
    sw(32'h1000_0102);
    sw(32'h1111_2222);
    sw(SYNC);
    check_eq("t3_err_cleared", 64'(cfg_error), 64'd0);
    sw(32'h1000_0014);
    check_eq("t3_frame_range_err", 64'(cfg_error), 64'd1);
    sw(SYNC);

    // Back-to-back writes, then DESYNC.
    sw(32'h1000_0000);
    send_word(32'h0000_00A1, 0, acc_a);
    sw(32'h1007_0013);
    send_word(32'h0000_00B2, 0, acc_b);
    check_eq("t4_throughput", 64'(acc_b - acc_a), 64'd4);
    sw(32'h0000_0000);
    check_eq("t4_done_pulse", 64'(cfg_done), 64'd1);
    check_eq("t4_idle_busy", 64'(cfg_busy), 64'd0);
    @(negedge CLK); #1;
    check_eq("t4_done_single", 64'(cfg_done), 64'd0);

    // Checksum command.
    sw(SYNC);
    sw(32'h1000_0000);
    sw(32'h0000_0001);
    sw(32'h1000_0001);
    sw(32'h0000_0002);
    sw(32'h2000_0000);
`ifdef CONFIG_CHECKSUM_EN
    sw(32'h0000_0003);
    check_eq("t5_sum_match", 64'(cfg_error), 64'd0);
    sw(32'h2000_0000);
    sw(32'h0000_0004);
    check_eq("t5_sum_mismatch", 64'(cfg_error), 64'd1);
`else
    check_eq("t5_check_illegal", 64'(cfg_error), 64'd1);
`endif
    sw(SYNC);
    sw(32'h0000_0000);

    // Reset while the strobe is high.
    sw(SYNC);
    sw(32'h1000_0102);
    send_word(32'hA5A5_5A5A, 0, acc_a);
    @(negedge CLK); #1;
    check_eq("t6_strobe_pre", 64'($countones(FrameStrobe)), 64'd1);
    RST = 1'b1;
    #1;
    check_eq("t6_strobe_async", 64'($countones(FrameStrobe)), 64'd0);
    check_eq("t6_frame_data", 64'(FrameData), 64'd0);
    check_eq("t6_busy", 64'(cfg_busy), 64'd0);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check_eq("t6_ready", 64'(bus.s_ready), 64'd1);

    // Randomized stream.
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 19));
      if (m_session && !m_err && m_expect == EXP_DATA) begin
        w = $urandom();
      end else if (m_session && !m_err && m_expect == EXP_SUM) begin
        w = ($urandom_range(0, 1) == 1) ? m_sum : (m_sum ^ (32'd1 << $urandom_range(0, 31)));
      end else if (r < 2) begin
        w = SYNC;
      end else if (r < 10) begin
        w = {4'h1, 12'($urandom()), 8'($urandom_range(0, NC - 1)), 8'($urandom_range(0, FPC - 1))};
      end else if (r < 12) begin
        w = {4'h1, 12'($urandom()), 8'($urandom_range(NC, 255)), 8'($urandom_range(0, 255))};
      end else if (r < 13) begin
        w = {4'h1, 12'($urandom()), 8'($urandom_range(0, NC - 1)), 8'($urandom_range(FPC, 255))};
      end else if (r < 15) begin
        w = {4'h0, 28'($urandom())};
      end else if (r < 17) begin
        w = {4'h2, 28'($urandom())};
      end else if (r < 18) begin
        w = {4'($urandom_range(3, 15)), 28'($urandom())};
      end else begin
        w = $urandom();
      end
      send_word(w, int'($urandom_range(0, 2)), acc_tmp);
    end

    repeat (5) @(negedge CLK);
    check_eq("pending_strobes", 64'(exp_q.size()), 64'd0);
    check_eq("done_pulses", 64'(done_seen), 64'(m_done_cnt));

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
